// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - segment glyph constants and digit count for the display scanner
package seg_pkg;

  localparam int NDIG = 4;

  // Active-high {g,f,e,d,c,b,a}; dp is handled separately by the scanner
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg_decode.sv
// rtl/seg_decode.sv - combinational BCD nibble to active-high 7-segment glyph
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_pat
);

  // Digits 0-9 map to their glyph; any non-BCD nibble shows E
  always_comb begin
    o_pat = SEG_E;
    case (i_nib)
      4'd0: o_pat = SEG_0;
      4'd1: o_pat = SEG_1;
      4'd2: o_pat = SEG_2;
      4'd3: o_pat = SEG_3;
      4'd4: o_pat = SEG_4;
      4'd5: o_pat = SEG_5;
      4'd6: o_pat = SEG_6;
      4'd7: o_pat = SEG_7;
      4'd8: o_pat = SEG_8;
      4'd9: o_pat = SEG_9;
      default: o_pat = SEG_E;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - 4-digit multiplexed 7-segment scanner; SEG_LZB_EN enables leading-zero blanking and minus placement
module seg_scan
  import seg_pkg::*;
#(
  parameter int CLK_DIV     = 50000,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit AN_ACT_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] dec,
  input  logic        neg,
  input  logic        dec_vld,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  localparam int             CW      = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [7:0]     SEG_OFF = SEG_ACT_LOW ? 8'hFF : 8'h00;
  localparam logic [3:0]     AN_OFF  = AN_ACT_LOW  ? 4'hF  : 4'h0;

  logic [15:0]   r_val;
  logic          r_neg;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [7:0]    r_seg;
  logic [3:0]    r_an;

  logic [3:0]    w_nib;
  logic [6:0]    w_pat;
  logic [7:0]    w_seg_ah;
  logic [3:0]    w_an_ah;

  // Shadow copy of the value being displayed, refreshed only on the strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_val <= 16'h0000;
      r_neg <= 1'b0;
    end else if (dec_vld) begin
      r_val <= dec;
      r_neg <= neg;
    end
  end

  // Slot prescaler; the digit index steps on each wrap, 3 rolls straight to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_nib = r_val[4*r_idx +: 4];

  seg_decode u_decode (
    .i_nib (w_nib),
    .o_pat (w_pat)
  );

`ifdef SEG_LZB_EN
  logic [1:0] w_msd;

  // Most-significant non-zero nibble; an all-zero value still shows digit 0
  always_comb begin
    w_msd = 2'd0;
    for (int i = 1; i < NDIG; i++) begin
      if (r_val[4*i +: 4] != 4'd0) w_msd = 2'(i);
    end
  end

  // Blank above the MSD, minus in the first blank slot, dp on digit 3 if no slot is free
  always_comb begin
    w_seg_ah = {1'b0, w_pat};
    if (r_idx > w_msd) begin
      w_seg_ah = (r_neg && (r_idx == w_msd + 2'd1)) ? {1'b0, SEG_MINUS} : {1'b0, SEG_BLANK};
    end
    if (r_neg && (w_msd == 2'd3) && (r_idx == 2'd3)) w_seg_ah[7] = 1'b1;
  end
`else
  // Every digit shows its nibble; the sign is only the dp of digit 3
  always_comb begin
    w_seg_ah = {1'b0, w_pat};
    if (r_neg && (r_idx == 2'd3)) w_seg_ah[7] = 1'b1;
  end
`endif

  assign w_an_ah = 4'b0001 << r_idx;

  // Segment and anode registered together so they can never disagree on the pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= SEG_OFF;
      r_an  <= AN_OFF;
    end else begin
      r_seg <= SEG_ACT_LOW ? ~w_seg_ah : w_seg_ah;
      r_an  <= AN_ACT_LOW  ? ~w_an_ah  : w_an_ah;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule
